tick_period_meter: RTL and testbench

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

---
 rtl/tick_period_meter.sv | 109 ++++++++++
 tb/tb_tick_period_meter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures the interval between rising edges of an asynchronous tick in enabled clk cycles,
// flags a match against an expected period, lock between consecutive periods, and signal loss.
module tick_period_meter #(
  parameter int unsigned    W          = 26,
  parameter logic [W-1:0]   TIMEOUT    = 26'd50_000_000,
  parameter logic [W-1:0]   EXP_PERIOD = 26'd833_334,
  parameter logic [W-1:0]   TOL        = 26'd1
) (
  input  logic         clk,
  input  logic         i_Rst,
  input  logic         i_CE,
  input  logic         i_tick,
  output logic [W-1:0] o_period,
  output logic         o_valid,
  output logic         o_match,
  output logic         o_locked,
  output logic         o_timeout
);

  // state   | meaning
  // IDLE    | no edge seen since reset; first edge only arms the counter
  // MEASURE | counting enabled cycles since the last edge
  // LOST    | no edge for TIMEOUT cycles; next edge re-arms without a measurement
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOST    = 2'd2;

  localparam logic [W-1:0] ONE = W'(1);

  logic [1:0]   state;
  logic         sync1;
  logic         sync2;
  logic         tick_prev;
  logic         edge_det;
  logic [W-1:0] cnt;
  logic [W-1:0] prev_period;
  logic         prev_valid;
  logic         valid_q;

  function automatic logic within_tol(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= TOL);
  endfunction

  assign edge_det = sync2 & ~tick_prev;

  // The strobe register holds with everything else while disabled, so it is
  // masked here to keep it from being seen during a disabled cycle.
  assign o_valid = valid_q & i_CE;

  always_ff @(posedge clk) begin
    if (!i_Rst) begin
      state       <= S_IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      tick_prev   <= 1'b0;
      cnt         <= '0;
      prev_period <= '0;
      prev_valid  <= 1'b0;
      valid_q     <= 1'b0;
      o_period    <= '0;
      o_match     <= 1'b0;
      o_locked    <= 1'b0;
      o_timeout   <= 1'b0;
    end else if (i_CE) begin
      sync1     <= i_tick;
      sync2     <= sync1;
      tick_prev <= sync2;
      valid_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (edge_det) begin
            state <= S_MEASURE;
            cnt   <= ONE;
          end
        end
        S_MEASURE: begin
          // An edge in the same cycle as the terminal count is still measured.
          if (edge_det) begin
            o_period    <= cnt;
            valid_q     <= 1'b1;
            o_match     <= within_tol(cnt, EXP_PERIOD);
            o_locked    <= prev_valid && within_tol(cnt, prev_period);
            prev_period <= cnt;
            prev_valid  <= 1'b1;
            cnt         <= ONE;
          end else if (cnt == TIMEOUT) begin
            state      <= S_LOST;
            o_timeout  <= 1'b1;
            o_locked   <= 1'b0;
            prev_valid <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_LOST: begin
          if (edge_det) begin
            state     <= S_MEASURE;
            cnt       <= ONE;
            o_timeout <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter: a timestamp-based model predicts measurements
// and timeout transitions; a negedge monitor compares them as the DUT presents them.
module tb_tick_period_meter;

  localparam int W       = 8;
  localparam int TIMEOUT = 100;
  localparam int EXP     = 10;
  localparam int TOL     = 1;

  logic         clk;
  logic         rst;
  logic         ce;
  logic         tick;
  logic [W-1:0] o_period;
  logic         o_valid;
  logic         o_match;
  logic         o_locked;
  logic         o_timeout;

  tick_period_meter #(
    .W(W), .TIMEOUT(8'd100), .EXP_PERIOD(8'd10), .TOL(8'd1)
  ) dut (
    .clk(clk), .i_Rst(rst), .i_CE(ce), .i_tick(tick),
    .o_period(o_period), .o_valid(o_valid), .o_match(o_match),
    .o_locked(o_locked), .o_timeout(o_timeout)
  );

  typedef struct {int period; bit match; bit locked;} exp_t;
  typedef struct {int idx; bit level;} tmo_t;

  exp_t exp_q[$];
  tmo_t tq[$];
  int   sched[$];

  int checks = 0;
  int errors = 0;
  int ce_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Reference model: works on enabled-cycle timestamps of detected edges.
  int  k = 0;
  bit  prev_sample = 0;
  bit  armed = 0;
  bit  lost = 0;
  bit  m_tmo = 0;
  bit  have_prev = 0;
  int  prev_p = 0;
  int  last_k = 0;

  function automatic int absdiff(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    tmo_t t;
    bit   is_edge;
    int   d;
    if (rst !== 1'b1) begin
      if (m_tmo) begin
        t.idx = k; t.level = 1'b0; tq.push_back(t);
        m_tmo = 0;
      end
      prev_sample = 0; armed = 0; lost = 0; have_prev = 0;
      sched.delete();
    end else if (ce) begin
      k++;
      // an edge sampled now is acted on two enabled cycles later
      if (tick && !prev_sample) sched.push_back(k + 2);
      prev_sample = tick;
      is_edge = (sched.size() > 0) && (sched[0] == k);
      if (is_edge) void'(sched.pop_front());
      if (armed && !lost) begin
        d = k - last_k;
        if (is_edge) begin
          e.period = d;
          e.match  = (absdiff(d, EXP) <= TOL);
          e.locked = have_prev && (absdiff(d, prev_p) <= TOL);
          exp_q.push_back(e);
          prev_p = d; have_prev = 1; last_k = k;
        end else if (d == TIMEOUT) begin
          lost = 1; have_prev = 0; m_tmo = 1;
          t.idx = k; t.level = 1'b1; tq.push_back(t);
        end
      end else if (is_edge) begin
        if (m_tmo) begin
          t.idx = k; t.level = 1'b0; tq.push_back(t);
          m_tmo = 0;
        end
        armed = 1; lost = 0; last_k = k;
      end
    end
  end

  // Monitor
  logic last_tmo = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    tmo_t t;
    if (rst === 1'b1) begin
      if (!ce) chk("valid_while_ce_low", o_valid, 0);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid actual=period %0d required=no strobe", o_period);
        end else begin
          e = exp_q.pop_front();
          chk("period", o_period, e.period);
          chk("match", o_match, e.match);
          chk("locked", o_locked, e.locked);
          chk("timeout_on_valid", o_timeout, 0);
        end
      end
    end
    if (o_timeout !== last_tmo) begin
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_timeout_change actual=%0b required=%0b", o_timeout, last_tmo);
      end else begin
        t = tq.pop_front();
        chk("timeout_level", o_timeout, t.level);
        chk("timeout_cycle", k, t.idx);
      end
      last_tmo = o_timeout;
    end
  end

  task automatic cyc(input bit t);
    @(posedge clk);
    #1;
    tick = t;
    case (ce_mode)
      0: ce = 1'b1;
      1: ce = ~ce;
      2: ce = ($urandom_range(0, 3) != 0);
      default: ce = 1'b0;
    endcase
  endtask

  task automatic pulse(input int n, input int hi);
    for (int i = 0; i < n; i++) cyc(i < hi);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_period", o_period, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_match", o_match, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_timeout", o_timeout, 0);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; tick = 1'b0;
    cyc(0); cyc(0);
    check_reset_outputs();
    cyc(0);
    rst = 1'b1;
    repeat (3) cyc(0);

    // steady period, then a jump out of tolerance
    repeat (4) pulse(10, 1);
    pulse(13, 2);
    repeat (3) pulse(10, 1);
    pulse(9, 1);
    pulse(11, 3);

    // loss of signal, then recovery
    pulse(10, 1);
    repeat (150) cyc(0);
    repeat (3) pulse(7, 1);

    // edge on the terminal count, then one cycle beyond it
    pulse(100, 1);
    pulse(100, 1);
    pulse(101, 1);
    repeat (3) pulse(10, 1);

    // enable toggling every cycle
    ce_mode = 1;
    repeat (4) pulse(20, 2);

    // random enable and random periods
    ce_mode = 2;
    repeat (15) pulse($urandom_range(4, 40), $urandom_range(1, 3));
    ce_mode = 0;
    repeat (15) pulse($urandom_range(8, 12), $urandom_range(1, 3));

    // reset mid-measurement with enable low
    repeat (2) pulse(10, 1);
    cyc(1);
    repeat (6) cyc(0);
    rst = 1'b0; ce_mode = 3;
    cyc(0); cyc(0);
    check_reset_outputs();
    rst = 1'b1; ce_mode = 0;
    repeat (3) pulse(10, 1);

    repeat (10) cyc(0);
    @(negedge clk);
    chk("pending_valids", exp_q.size(), 0);
    chk("pending_timeouts", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
